// File: rtl/mod_reduce_p25519_if.sv
// ----------------------------------------------------------------------------
// mod_reduce_p25519_if
//   Stream bundle for the p = 2^WIDTH - C reducer. It carries the input stream
//   (unreduced value) and the output stream (canonical value). Both streams
//   use a valid/ready handshake.
//
//   Signals
//     in_valid   producer -> reducer  in_data is valid this cycle
//     in_ready   reducer  -> producer reducer accepts in_data this cycle
//     in_data    producer -> reducer  unreduced value, WIDTH+1 bits
//     out_valid  reducer  -> consumer out_data is valid
//     out_ready  consumer -> reducer  consumer accepts out_data
//     out_data   reducer  -> consumer canonical value in [0, p), WIDTH bits
//
//   Modports
//     master  the environment around the reducer (producer + consumer)
//     slave   the reducer itself
// ----------------------------------------------------------------------------
interface mod_reduce_p25519_if #(
    parameter int unsigned WIDTH = 255
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH:0]   in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/mod_reduce_p25519.sv
// ----------------------------------------------------------------------------
// mod_reduce_p25519
//   Canonicalises an unreduced (WIDTH+1)-bit field value x into [0, p), where
//   p = 2^WIDTH - C. The intended source is the add/sub stage, which emits
//   values below 2p, but any x in [0, 2^(WIDTH+1)) is reduced correctly.
//   The block is a 2-stage valid/ready pipeline. It delivers 1 result per
//   cycle, and a result appears 2 cycles after its input is accepted.
//
//   Stage 1 (fold)           t = x[WIDTH-1:0] + (x[WIDTH] ? C : 0), t < 2p
//   Stage 2 (final subtract) out = (t >= p) ? t - p : t
//
//   Parameters
//     WIDTH  field element width (p = 2^WIDTH - C)
//     C      modulus offset, 0 < C < 2^(WIDTH-8)
//
//   Ports
//     clk        clock; all state updates on posedge
//     rst        synchronous, active-high reset
//     io         stream bundle (slave side), see mod_reduce_p25519_if
//     red_count  number of final-subtract events, saturating at 2^32-1
//                (present only when MODRED_CNT_EN is defined)
//
//   Build option
//     MODRED_CNT_EN  adds the red_count port and its counter. The datapath is
//                    the same with or without this option.
// ----------------------------------------------------------------------------
module mod_reduce_p25519 #(
    parameter int unsigned WIDTH = 255,
    parameter int unsigned C     = 19
) (
    input  logic                        clk,
    input  logic                        rst,
    mod_reduce_p25519_if.slave          io
`ifdef MODRED_CNT_EN
    ,
    output logic [31:0]                 red_count
`endif
);

    localparam logic [WIDTH:0] C_T = (WIDTH+1)'(C);
    localparam logic [WIDTH:0] P_T = {1'b1, {WIDTH{1'b0}}} - C_T;

    // Stage 1: folded value t
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH:0]   t_q, t_d;
    // Stage 2: output register
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] out_q, out_d;

    logic             s2_adv;
    logic             s1_adv;
    logic             in_rdy;
    logic             accept;
    logic [WIDTH:0]   fold;
    logic             sub_ok;
    logic [WIDTH-1:0] red;

    // The sign of t - p at WIDTH+2 bits is equal to (t < p). Because t < 2p,
    // the low WIDTH bits of t - p are the complete result when t >= p.
    always_comb begin
        fold   = {1'b0, io.in_data[WIDTH-1:0]} + (io.in_data[WIDTH] ? C_T : '0);
        sub_ok = (t_q >= P_T);
        red    = sub_ok ? WIDTH'(t_q - P_T) : t_q[WIDTH-1:0];
    end

    always_comb begin
        s2_adv     = !s2_valid_q | io.out_ready;
        s1_adv     = s1_valid_q & s2_adv;
        in_rdy     = !s1_valid_q | s1_adv;
        accept     = io.in_valid & in_rdy;

        s1_valid_d = s1_valid_q;
        t_d        = t_q;
        s2_valid_d = s2_valid_q;
        out_d      = out_q;

        // An accept can happen in the same cycle as s1 drains into s2.
        // In that cycle the new value replaces the old one in the register.
        if (accept) begin
            s1_valid_d = 1'b1;
            t_d        = fold;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_d = red;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            t_q        <= '0;
            s2_valid_q <= 1'b0;
            out_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            t_q        <= t_d;
            s2_valid_q <= s2_valid_d;
            out_q      <= out_d;
        end
    end

    assign io.in_ready  = in_rdy;
    assign io.out_valid = s2_valid_q;
    assign io.out_data  = out_q;

`ifdef MODRED_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    // The counter counts stage-2 loads that subtract p. It saturates at its maximum value.
    always_comb begin
        cnt_d = cnt_q;
        if (s1_adv && sub_ok && (cnt_q != '1)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign red_count = cnt_q;
`endif

endmodule
